// File: rtl/pipeline_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Also holds the static branch predictor offset used when FETCH_STATIC_BP_EN is defined.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'd90;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] pred;
    } fetch_entry_t;

    // Offset from the instruction's PC to its predicted successor.
    function automatic logic [31:0] static_bp_offset(input logic [31:0] instr);
        logic [31:0] off;
        off = 32'd4;
        if (instr[6:0] == OPC_JAL) begin
            off = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        end else if (instr[6:0] == OPC_BRANCH && instr[31]) begin
            off = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        end
        return off;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer with push, pop and flush; head entry is read combinationally.
module fetch_fifo #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned WIDTH      = 160,
    parameter int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q < DEPTH_C) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (reset && !flush && do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction fetch stage: one outstanding read, small buffer, redirect flush.
// Define FETCH_STATIC_BP_EN to predict JAL and backward branches from the fetched word.
module pipeline_fetch
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH/2-1:0] mem_resp_data,
    input  logic                    next_stage_ready,
    output logic [DATA_WIDTH/2-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]   instruction_pc,
    output logic [ADDR_WIDTH-1:0]   bp_target
);

    localparam int unsigned IW = DATA_WIDTH / 2;
    localparam int unsigned EW = IW + 2 * ADDR_WIDTH;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] pred;
    logic                  push, pop, flush, req_fire, busy_after;
    logic [EW-1:0]         head;
    logic [CW-1:0]         count;

`ifdef FETCH_STATIC_BP_EN
    logic [31:0] bp_off;
    always_comb begin
        bp_off = static_bp_offset(mem_resp_data[31:0]);
        pred   = fetch_pc_q + {{(ADDR_WIDTH - 32){bp_off[31]}}, bp_off};
    end
`else
    assign pred = fetch_pc_q + ADDR_WIDTH'(4);
`endif

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        mem_req_valid = 1'b0;
        push          = 1'b0;
        flush         = 1'b0;
        pop           = next_stage_ready && (count != '0) && !redirect_valid;
        unique case (state_q)
            S_REQ: begin
                mem_req_valid = reset && (count < DEPTH_C) && !redirect_valid;
                if (mem_req_valid && mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    push       = 1'b1;
                    fetch_pc_d = pred;
                    state_d    = S_REQ;
                end
            end
            S_DISCARD: begin
                if (mem_resp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        req_fire = mem_req_valid && mem_req_ready;
        // A response landing with the redirect retires the outstanding read.
        busy_after = req_fire ||
                     ((state_q == S_WAIT || state_q == S_DISCARD) && !mem_resp_valid);
        if (redirect_valid) begin
            flush      = 1'b1;
            push       = 1'b0;
            fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            state_d    = busy_after ? S_DISCARD : S_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .WIDTH     (EW),
        .CW        (CW)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .flush(flush),
        .wdata({mem_resp_data, fetch_pc_q, pred}),
        .head (head),
        .count(count)
    );

    assign mem_req_addr = fetch_pc_q;

    always_comb begin
        instruction    = IW'(NOP_INSTR);
        instruction_pc = '0;
        bp_target      = '0;
        if (reset && count != '0) begin
            instruction    = head[EW-1 -: IW];
            instruction_pc = head[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
            bp_target      = head[ADDR_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_pipeline_fetch.sv
// Self-checking bench for pipeline_fetch: directed vector table, then random traffic
// against a queue-based reference model.
module tb_pipeline_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        next_stage_ready;
    logic [31:0] instruction;
    logic [63:0] instruction_pc;
    logic [63:0] bp_target;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .next_stage_ready(next_stage_ready),
        .instruction     (instruction),
        .instruction_pc  (instruction_pc),
        .bp_target       (bp_target)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        redir;
        logic [63:0] redir_pc;
        logic        req_ready;
        logic        resp_valid;
        logic [31:0] resp_data;
        logic        ns_ready;
        logic        exp_valid;
        logic [63:0] exp_addr;
        logic [31:0] exp_instr;
        logic [63:0] exp_pc;
        logic [63:0] exp_bp;
    } vec_t;

    function automatic vec_t mk(input logic rst_n, input logic redir, input logic [63:0] rpc,
                                input logic rq_rdy, input logic rsp, input logic [31:0] rdata,
                                input logic ns, input logic ev, input logic [63:0] ea,
                                input logic [31:0] ei, input logic [63:0] ep,
                                input logic [63:0] eb);
        vec_t v;
        v.rst_n = rst_n; v.redir = redir; v.redir_pc = rpc; v.req_ready = rq_rdy;
        v.resp_valid = rsp; v.resp_data = rdata; v.ns_ready = ns;
        v.exp_valid = ev; v.exp_addr = ea; v.exp_instr = ei; v.exp_pc = ep; v.exp_bp = eb;
        return v;
    endfunction

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] pred;
    } ent_t;

    // Predicted successor computed from the instruction fields as signed integers.
    function automatic logic [63:0] model_pred(input logic [63:0] pc, input logic [31:0] ins);
`ifdef FETCH_STATIC_BP_EN
        longint imm;
        if (ins[6:0] == 7'h6f) begin
            imm = longint'(ins[30:21]) * 2 + longint'(ins[20]) * 2048 +
                  longint'(ins[19:12]) * 4096 - (ins[31] ? 64'sd1048576 : 64'sd0);
            return pc + 64'(imm);
        end
        if (ins[6:0] == 7'h63 && ins[31]) begin
            imm = longint'(ins[11:8]) * 2 + longint'(ins[30:25]) * 32 +
                  longint'(ins[7]) * 2048 - 64'sd4096;
            return pc + 64'(imm);
        end
`endif
        return pc + 64'd4;
    endfunction

`ifdef FETCH_STATIC_BP_EN
    localparam logic [63:0] BP_T = 64'hF8;
`else
    localparam logic [63:0] BP_T = 64'h104;
`endif

    vec_t vecs[$];

    ent_t        mq[$];
    logic [63:0] m_pc;
    logic        m_busy, m_stale;
    logic        mem_pending;
    int unsigned mem_lat;

    initial begin
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0; next_stage_ready = 1'b0;

        //             rst re rpc       rrdy rsp data          ns  ev  addr     instr         pc       bp
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,            0,  0, 0,       90,           0,       0));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,            0,  0, 0,       90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       1, 0, 0,            1,  1, 0,       90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       1, 1, 32'h13,       1,  0, 0,       90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       1, 0, 0,            1,  1, 4,       32'h13,       0,       4));
        vecs.push_back(mk(1, 0, 0,       1, 1, 32'h13,       1,  0, 0,       90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       1, 0, 0,            1,  1, 8,       32'h13,       4,       8));
        vecs.push_back(mk(1, 0, 0,       1, 1, 32'h13,       0,  0, 0,       90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       1, 0, 0,            0,  1, 12,      32'h13,       8,       12));
        vecs.push_back(mk(1, 0, 0,       1, 1, 32'h00100093, 0,  0, 0,       32'h13,       8,       12));
        vecs.push_back(mk(1, 0, 0,       1, 0, 0,            0,  0, 0,       32'h13,       8,       12));
        vecs.push_back(mk(1, 0, 0,       1, 0, 0,            0,  0, 0,       32'h13,       8,       12));
        vecs.push_back(mk(1, 0, 0,       1, 0, 0,            1,  0, 0,       32'h13,       8,       12));
        vecs.push_back(mk(1, 0, 0,       1, 0, 0,            0,  1, 16,      32'h00100093, 12,      16));
        vecs.push_back(mk(1, 1, 'h1003,  1, 0, 0,            0,  0, 0,       32'h00100093, 12,      16));
        vecs.push_back(mk(1, 0, 0,       1, 1, 32'h13,       0,  0, 0,       90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       1, 0, 0,            0,  1, 'h1000,  90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       1, 1, 32'h00200113, 0,  0, 0,       90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       1, 0, 0,            0,  1, 'h1004,  32'h00200113, 'h1000,  'h1004));
        vecs.push_back(mk(1, 1, 'h2000,  1, 1, 32'h13,       0,  0, 0,       32'h00200113, 'h1000,  'h1004));
        vecs.push_back(mk(1, 0, 0,       1, 0, 0,            0,  1, 'h2000,  90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       1, 1, 32'h13,       0,  0, 0,       90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       1, 0, 0,            0,  1, 'h2004,  32'h13,       'h2000,  'h2004));
        vecs.push_back(mk(0, 0, 0,       1, 0, 0,            0,  0, 0,       90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       0, 0, 0,            0,  1, 0,       90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       0, 0, 0,            0,  1, 0,       90,           0,       0));
        vecs.push_back(mk(1, 1, 'h100,   0, 0, 0,            0,  0, 0,       90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       1, 0, 0,            0,  1, 'h100,   90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       1, 1, 32'hFF9FF06F, 0,  0, 0,       90,           0,       0));
        vecs.push_back(mk(1, 0, 0,       0, 0, 0,            0,  1, BP_T,    32'hFF9FF06F, 'h100,   BP_T));

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            reset            = vecs[i].rst_n;
            redirect_valid   = vecs[i].redir;
            redirect_pc      = vecs[i].redir_pc;
            mem_req_ready    = vecs[i].req_ready;
            mem_resp_valid   = vecs[i].resp_valid;
            mem_resp_data    = vecs[i].resp_data;
            next_stage_ready = vecs[i].ns_ready;
            @(negedge clk);
            chk($sformatf("vec%0d req_valid", i), 64'(mem_req_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) chk($sformatf("vec%0d req_addr", i), mem_req_addr,
                                       vecs[i].exp_addr);
            chk($sformatf("vec%0d instr", i), 64'(instruction), 64'(vecs[i].exp_instr));
            chk($sformatf("vec%0d pc", i), instruction_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d bp", i), bp_target, vecs[i].exp_bp);
            @(posedge clk);
            #1;
        end

        // Random traffic against the reference model; begins with a reset.
        mq.delete();
        m_pc = '0; m_busy = 1'b0; m_stale = 1'b0;
        mem_pending = 1'b0; mem_lat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        exp_valid, fire_exp, dut_fire;
            ent_t        e;
            reset          = (cyc < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = {32'h0, $urandom} & 64'h0000_0000_0000_fffe;
            if ($urandom_range(0, 3) == 0) redirect_pc[0] = 1'b1;
            mem_req_ready    = ($urandom_range(0, 9) < 7);
            next_stage_ready = ($urandom_range(0, 9) < 6);
            mem_resp_valid   = mem_pending && (mem_lat == 0);
            mem_resp_data    = $urandom;
            @(negedge clk);
            exp_valid = reset && !m_busy && (mq.size() < 2) && !redirect_valid;
            chk("rnd req_valid", 64'(mem_req_valid), 64'(exp_valid));
            if (exp_valid) chk("rnd req_addr", mem_req_addr, m_pc);
            if (reset && mq.size() > 0) begin
                chk("rnd instr", 64'(instruction), 64'(mq[0].instr));
                chk("rnd pc", instruction_pc, mq[0].pc);
                chk("rnd bp", bp_target, mq[0].pred);
            end else begin
                chk("rnd instr", 64'(instruction), 64'd90);
                chk("rnd pc", instruction_pc, 64'd0);
                chk("rnd bp", bp_target, 64'd0);
            end
            fire_exp = exp_valid && mem_req_ready;
            dut_fire = mem_req_valid && mem_req_ready;
            @(posedge clk);
            if (!reset) begin
                mq.delete();
                m_pc = '0; m_busy = 1'b0; m_stale = 1'b0;
                mem_pending = 1'b0;
            end else begin
                if (redirect_valid) begin
                    mq.delete();
                    m_pc = redirect_pc & ~64'h3;
                    if (m_busy && mem_resp_valid) m_busy = 1'b0;
                    else if (m_busy || fire_exp) begin
                        m_busy = 1'b1; m_stale = 1'b1;
                    end
                end else begin
                    if (next_stage_ready && mq.size() > 0) void'(mq.pop_front());
                    if (m_busy && mem_resp_valid) begin
                        if (!m_stale) begin
                            e.instr = mem_resp_data;
                            e.pc    = m_pc;
                            e.pred  = model_pred(m_pc, mem_resp_data);
                            mq.push_back(e);
                            m_pc = e.pred;
                        end
                        m_busy = 1'b0; m_stale = 1'b0;
                    end
                    if (fire_exp) begin
                        m_busy = 1'b1; m_stale = 1'b0;
                    end
                end
                if (mem_resp_valid) mem_pending = 1'b0;
                else if (mem_pending) mem_lat--;
                if (dut_fire) begin
                    mem_pending = 1'b1;
                    mem_lat     = $urandom_range(0, 2);
                end
            end
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_fetch.md
Name: pipeline_fetch

Overview:
- Instruction fetch stage, directly upstream of the decode stage.
- Issues one outstanding 32-bit instruction read at a time to the instruction memory port and buffers returned instructions in a small FIFO.
- Presents each instruction to decode with its PC and predicted next PC (bp_target).
- Redirects from branch resolution flush the buffer and drop any in-flight stale response; decode sees bubbles as the NOP encoding 90.

Parameters:
- ADDR_WIDTH, 64, PC/address width.
- DATA_WIDTH, 64, datapath width; instruction width is DATA_WIDTH/2.
- FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2).
- RESET_PC, 64'h0, PC fetched first after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- redirect_valid  in  1  branch/jump resolution requests a PC change.
- redirect_pc  in  ADDR_WIDTH  new fetch PC; bits [1:0] are forced to 0.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_WIDTH  request address.
- mem_resp_valid  in  1  read data returned (one per accepted request, in order).
- mem_resp_data  in  DATA_WIDTH/2  instruction word.
- next_stage_ready  in  1  decode ready; head entry is consumed when high.
- instruction  out  DATA_WIDTH/2  FIFO head, or 90 when empty.
- instruction_pc  out  ADDR_WIDTH  PC of head entry, 0 when empty.
- bp_target  out  ADDR_WIDTH  predicted next PC of head entry, 0 when empty.

Behaviour:
- Reset (reset==0 at posedge):
  - state=S_REQ, fetch_pc=RESET_PC, FIFO empty.
  - mem_req_valid=0 during reset; instruction=90, instruction_pc=0, bp_target=0.
- State machine:
  - S_REQ:
    - mem_req_valid = (count<FIFO_DEPTH) && !redirect_valid; mem_req_addr=fetch_pc.
    - Handshake (valid&&ready) -> S_WAIT.
  - S_WAIT:
    - mem_req_valid=0.
    - On mem_resp_valid: push {mem_resp_data, fetch_pc, pred}; fetch_pc<=pred; -> S_REQ.
  - S_DISCARD:
    - mem_req_valid=0.
    - On mem_resp_valid: drop the data -> S_REQ.
- pred = fetch_pc+4 (default build). Arithmetic is modulo 2^ADDR_WIDTH.
- First mem_req_valid=1 occurs in the first cycle after reset deasserts.
- Response to instruction latency: data valid in cycle N appears on instruction in cycle N+1 (FIFO registered, outputs combinational from head).
- Pop: when next_stage_ready && count>0. Push and pop in the same cycle are both honoured; count is unchanged. Full FIFO blocks issue only, never the in-flight push, because a slot is reserved at issue.
- Redirect (has priority over everything):
  - FIFO flushed and fetch_pc<=redirect_pc in the same cycle.
  - If in S_WAIT, or S_REQ with a handshake that cycle -> S_DISCARD; otherwise -> S_REQ.
  - A mem_resp_valid coinciding with redirect is dropped.
  - Same-cycle pop has no further effect.
  - A redirect arriving while in S_DISCARD stays in S_DISCARD and updates fetch_pc.
- mem_resp_valid in S_REQ is ignored (protocol error; the memory is reset together with this block).
- Reset mid-operation: all state returns to reset values within the same cycle; the outstanding request is abandoned.

Optional Feature:
- Macro: FETCH_STATIC_BP_EN.
- Defined: pred is computed from mem_resp_data with a static predictor:
  - opcode 1101111 (JAL): pred = fetch_pc + sign-extended J-immediate.
  - opcode 1100011 with imm[12]=1 (backward branch): pred = fetch_pc + sign-extended B-immediate.
  - Otherwise: pred = fetch_pc+4.
- Undefined: pred = fetch_pc+4 always.

Decomposition:
- Package pipeline_pkg holds:
  - NOP_INSTR = 32'd90.
  - OPC_JAL, OPC_BRANCH.
  - fetch_state_t enum {S_REQ, S_WAIT, S_DISCARD}.
  - fetch_entry_t struct {instr, pc, pred}.
- Sub-module fetch_fifo: parameterised FIFO_DEPTH circular buffer with push, pop, flush, count, head. Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset release, mem_req_ready=1, resp 1 cycle later with 32'h00000013, next_stage_ready=1 -> addresses 0,4,8 requested; instruction=32'h13, instruction_pc=0, bp_target=4 one cycle after the first resp.
- next_stage_ready=0 -> FIFO fills to 2 and mem_req_valid stays 0. Assert ready -> head pops, and one request issues the next cycle.
- Redirect to 0x1003 while in S_WAIT -> response for old PC dropped; next request addr=0x1000; no stale instruction on the output; instruction=90 meanwhile.
- Redirect in the same cycle as mem_resp_valid with FIFO holding 1 entry -> FIFO empty, response dropped, next addr=redirect_pc.
- reset pulled low while in S_WAIT with 2 entries -> next cycle instruction=90 and pc=0; after release the first request is addr RESET_PC.
- FETCH_STATIC_BP_EN: fetch 32'hFF9FF06F (JAL -8) at PC 0x100 -> bp_target=0xF8 and next request addr=0xF8. Without the macro -> bp_target=0x104.
